// File: rtl/arb_pkg.sv
// Shared arbitration types for the request-queue stage and the rrarb arbiter.
// Provides the requester count, index width, request vector type and grant decode helper.
package arb_pkg;

    localparam int NUM_REQ   = 4;
    localparam int REQ_IDX_W = 2;

    typedef logic [NUM_REQ-1:0]   req_vec_t;
    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    typedef struct packed {
        logic     hit;
        req_idx_t idx;
    } gnt_sel_t;

    // Multi-hot grants are illegal; the lowest set bit wins so behaviour stays defined.
    function automatic gnt_sel_t lowest_gnt(req_vec_t v);
        gnt_sel_t sel;
        sel.hit = 1'b0;
        sel.idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                sel.hit = 1'b1;
                sel.idx = req_idx_t'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; full/empty derive from the count only.
// Push is refused when full and pop is ignored when empty, so callers may strobe freely.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/arb_req_fifo.sv
// Per-requester queues feeding the rrarb round-robin arbiter, with a registered pop output.
// Define ARB_REQ_FIFO_OVF_EN to build the sticky per-channel overflow flags.
module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  req_vec_t                         push_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   data_i,
    output req_vec_t                         full_o,
    output req_vec_t                         req_o,
    input  req_vec_t                         gnt_i,
    output logic                             out_valid_o,
    output logic [DATA_W-1:0]                out_data_o,
    output logic [REQ_IDX_W-1:0]             out_src_o,
    output req_vec_t                         ovf_o
);

    gnt_sel_t          gsel;
    req_vec_t          pop_vec;
    req_vec_t          empty;
    logic [DATA_W-1:0] head [NUM_REQ];
    logic [DATA_W-1:0] sel_head_p0;
    logic              pop_fire_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    req_idx_t          src_p1;

    assign gsel = lowest_gnt(gnt_i);

    always_comb begin
        pop_vec = '0;
        if (gsel.hit) pop_vec[gsel.idx] = 1'b1;
    end

    // A grant to an empty queue is dropped here and inside the FIFO alike.
    assign pop_fire_p0 = gsel.hit & req_o[gsel.idx];
    assign sel_head_p0 = head[gsel.idx];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
        sync_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_i[i]),
            .pop   (pop_vec[i]),
            .wdata (data_i[i]),
            .head  (head[i]),
            .full  (full_o[i]),
            .empty (empty[i])
        );
    end

    assign req_o = ~empty;

    // ---- stage p0 -> p1: output register, loaded on the same edge that pops ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
        end else begin
            vld_p1 <= pop_fire_p0;
            if (pop_fire_p0) begin
                data_p1 <= sel_head_p0;
                src_p1  <= gsel.idx;
            end
        end
    end

    assign out_valid_o = vld_p1;
    assign out_data_o  = data_p1;
    assign out_src_o   = src_p1;

`ifdef ARB_REQ_FIFO_OVF_EN
    req_vec_t ovf_q;

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= ovf_q | (push_i & full_o);
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = '0;
`endif

endmodule

// File: tb/tb_arb_req_fifo.sv
// Self-checking bench for arb_req_fifo: queue-based reference model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_arb_req_fifo;
    import arb_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic                           clk = 1'b0;
    logic                           reset;
    req_vec_t                       push_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_i;
    req_vec_t                       full_o;
    req_vec_t                       req_o;
    req_vec_t                       gnt_i;
    logic                           out_valid_o;
    logic [DATA_W-1:0]              out_data_o;
    logic [REQ_IDX_W-1:0]           out_src_o;
    req_vec_t                       ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arb_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_i),
        .data_i      (data_i),
        .full_o      (full_o),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_src_o   (out_src_o),
        .ovf_o       (ovf_o)
    );

    // Reference model: one queue per channel, updated at each rising edge.
    logic [DATA_W-1:0] mq [4][$];
    logic              m_vld;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_src;
    logic [3:0]        m_ovf;
    bit                chk_en = 0;
    int                m_sz [4];
    int                m_k;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_vld  = 1'b0;
            m_data = '0;
            m_src  = '0;
            m_ovf  = '0;
            chk_en = 1;
        end else begin
            for (int i = 0; i < 4; i++) m_sz[i] = mq[i].size();
            m_k = -1;
            for (int i = 3; i >= 0; i--) if (gnt_i[i]) m_k = i;
            m_vld = 1'b0;
            if (m_k >= 0 && m_sz[m_k] > 0) begin
                m_data = mq[m_k].pop_front();
                m_src  = 2'(m_k);
                m_vld  = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (push_i[i]) begin
                    if (m_sz[i] == DEPTH) begin
`ifdef ARB_REQ_FIFO_OVF_EN
                        m_ovf[i] = 1'b1;
`endif
                    end else begin
                        mq[i].push_back(data_i[i]);
                    end
                end
            end
        end
    end

    logic [3:0] e_req, e_full;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                e_req[i]  = (mq[i].size() != 0);
                e_full[i] = (mq[i].size() == DEPTH);
            end
            n_tests++;
            if (req_o !== e_req || full_o !== e_full || out_valid_o !== m_vld ||
                out_data_o !== m_data || out_src_o !== m_src || ovf_o !== m_ovf) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t (dut/model) req=%b/%b full=%b/%b vld=%b/%b data=%h/%h src=%0d/%0d ovf=%b/%b",
                         $time, req_o, e_req, full_o, e_full, out_valid_o, m_vld,
                         out_data_o, m_data, out_src_o, m_src, ovf_o, m_ovf);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_idx(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    int src_seq [$];
    int rr_exp [6] = '{0, 1, 3, 0, 1, 3};
    int last, pick, cyc;

    initial begin
        reset  = 1'b1;
        push_i = 4'hF;
        gnt_i  = '0;
        data_i = {4{8'h5A}};
        step();
        step();
        check("rst_req",   req_o,       32'h0);
        check("rst_full",  full_o,      32'h0);
        check("rst_vld",   out_valid_o, 32'h0);
        check("rst_data",  out_data_o,  32'h0);
        check("rst_src",   out_src_o,   32'h0);
        check("rst_ovf",   ovf_o,       32'h0);
        reset  = 1'b0;
        push_i = '0;
        step();
        check("rst_nopush_req", req_o, 32'h0);

        // Two channels pushed together, ch3 granted first.
        push_i = 4'b1001; data_i[0] = 8'hA1; data_i[3] = 8'hB3;
        step();
        push_i = '0;
        check("push_req", req_o, 32'h9);
        gnt_i = 4'b1000;
        step();
        gnt_i = '0;
        check("pop3_vld",  out_valid_o, 32'h1);
        check("pop3_data", out_data_o,  32'hB3);
        check("pop3_src",  out_src_o,   32'h3);
        check("pop3_req",  req_o,       32'h1);
        gnt_i = 4'b0001;
        step();
        gnt_i = '0;
        check("pop0_data", out_data_o, 32'hA1);
        step();
        check("idle_vld", out_valid_o, 32'h0);
        check("idle_data_hold", out_data_o, 32'hA1);

        // Fill ch1, overflow, drain in order.
        for (int k = 0; k < 4; k++) begin
            push_i = 4'b0010; data_i[1] = 8'(8'h10 + k);
            step();
        end
        push_i = '0;
        check("fill_full", full_o, 32'h2);
        push_i = 4'b0010; data_i[1] = 8'h14;
        step();
        push_i = '0;
        check("ovf_full", full_o, 32'h2);
`ifdef ARB_REQ_FIFO_OVF_EN
        check("ovf_flag", ovf_o, 32'h2);
`else
        check("ovf_tied", ovf_o, 32'h0);
`endif
        gnt_i = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            step();
            check("drain1_vld",  out_valid_o, 32'h1);
            check("drain1_data", out_data_o,  32'(8'h10 + k));
            if (k == 0) check("full_clear", full_o, 32'h0);
        end
        step();
        gnt_i = '0;
        check("drain1_empty_vld", out_valid_o, 32'h0);
        check("drain1_req", req_o, 32'h0);

        // Pointer wrap on ch2.
        for (int k = 0; k < 6; k++) begin
            push_i = 4'b0100; data_i[2] = 8'(8'h20 + k);
            step();
            push_i = '0; gnt_i = 4'b0100;
            step();
            gnt_i = '0;
            check("wrap_data", out_data_o, 32'(8'h20 + k));
            check("wrap_src",  out_src_o,  32'h2);
        end
        check("wrap_ovf2", ovf_o[2], 32'h0);

        // Grant to empty channel, then multi-hot grant.
        gnt_i = 4'b0100;
        step();
        gnt_i = '0;
        check("gnt_empty_vld", out_valid_o, 32'h0);
        check("gnt_empty_req", req_o, 32'h0);
        push_i = 4'b0110; data_i[1] = 8'h31; data_i[2] = 8'h42;
        step();
        push_i = '0; gnt_i = 4'b0110;
        step();
        gnt_i = '0;
        check("multihot_src",  out_src_o,  32'h1);
        check("multihot_data", out_data_o, 32'h31);
        check("multihot_req",  req_o,      32'h4);
        gnt_i = 4'b0100;
        step();
        gnt_i = '0;
        check("multihot_rest", out_data_o, 32'h42);

        // Push into empty queue while granted: no pop that cycle.
        push_i = 4'b0001; gnt_i = 4'b0001; data_i[0] = 8'hA7;
        step();
        push_i = '0;
        check("pushgnt_vld", out_valid_o, 32'h0);
        check("pushgnt_req", req_o, 32'h1);
        step();
        gnt_i = '0;
        check("pushgnt_data", out_data_o, 32'hA7);

        // Round-robin arbiter in the loop.
        push_i = 4'b1011; data_i[0] = 8'h50; data_i[1] = 8'h60; data_i[3] = 8'h70;
        step();
        data_i[0] = 8'h51; data_i[1] = 8'h61; data_i[3] = 8'h71;
        step();
        push_i = '0;
        last = 3;
        cyc  = 0;
        while (src_seq.size() < 6 && cyc < 40) begin
            pick  = rr_idx(req_o, last);
            gnt_i = (pick >= 0) ? req_vec_t'(4'b0001 << pick) : '0;
            if (pick >= 0) last = pick;
            step();
            cyc++;
            if (out_valid_o) src_seq.push_back(int'(out_src_o));
        end
        gnt_i = '0;
        check("rr_count", src_seq.size(), 32'd6);
        for (int k = 0; k < src_seq.size() && k < 6; k++) check("rr_src", src_seq[k], rr_exp[k]);
        check("rr_req_end", req_o, 32'h0);

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++)
                push_i[i] = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 4; i++) data_i[i] = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r < 4)      gnt_i = '0;
            else if (r < 9) gnt_i = req_vec_t'(4'b0001 << $urandom_range(0, 3));
            else            gnt_i = req_vec_t'($urandom);
            step();
        end
        reset  = 1'b0;
        push_i = '0;
        gnt_i  = '0;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
